// File: rtl/uart_frame_tx_ctrl.sv
// uart_frame_tx_ctrl: word FIFO plus framer that feeds a byte-serial UART transmitter.
// Define FRAME_SEQ_EN to insert a rolling 8-bit sequence byte after SYNC.
module uart_frame_tx_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_done
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SYNC,
`ifdef FRAME_SEQ_EN
    S_SEQ,
`endif
    S_PAY,
    S_CSUM
  } frame_state_t;

  typedef enum logic [1:0] {
    B_ISSUE,
    B_ACK,
    B_DONE
  } byte_phase_t;

  // Word FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push_c;
  logic              pop_c;

  assign in_ready = (fifo_count != CW'(FIFO_DEPTH));
  assign push_c   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_c, pop_c})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Framer state
  frame_state_t      state_q, state_d;
  byte_phase_t       phase_q, phase_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, shreg_nxt;
  logic [7:0]        csum_q, csum_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        tx_data_d;
  logic              tx_start_d;
  logic              frame_done_d;
`ifdef FRAME_SEQ_EN
  logic [7:0]        seq_q, seq_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= B_ISSUE;
      shreg_q    <= '0;
      csum_q     <= '0;
      idx_q      <= '0;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
`ifdef FRAME_SEQ_EN
      seq_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      shreg_q    <= shreg_d;
      csum_q     <= csum_d;
      idx_q      <= idx_d;
      tx_data    <= tx_data_d;
      tx_start   <= tx_start_d;
      frame_done <= frame_done_d;
`ifdef FRAME_SEQ_EN
      seq_q      <= seq_d;
`endif
    end
  end

  // Next-state: frame sequencing with a per-byte issue/ack/done handshake
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    shreg_d      = shreg_q;
    csum_d       = csum_q;
    idx_d        = idx_q;
    tx_data_d    = tx_data;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    pop_c        = 1'b0;
    shreg_nxt    = shreg_q << 8;
`ifdef FRAME_SEQ_EN
    seq_d        = seq_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (fifo_count != '0) begin
          pop_c   = 1'b1;
          shreg_d = mem[rd_ptr];
          csum_d  = '0;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        tx_data_d = SYNC_BYTE;
        phase_d   = B_ISSUE;
        state_d   = S_SYNC;
      end

      default: begin
        case (phase_q)
          B_ISSUE: begin
            if (!tx_busy) begin
              tx_start_d = 1'b1;
              phase_d    = B_ACK;
              // SYNC and the checksum byte itself are excluded from csum
              if (state_q != S_SYNC && state_q != S_CSUM) csum_d = csum_q ^ tx_data;
            end
          end

          B_ACK: begin
            if (tx_busy) phase_d = B_DONE;
          end

          B_DONE: begin
            if (!tx_busy) begin
              phase_d = B_ISSUE;
              case (state_q)
                S_SYNC: begin
`ifdef FRAME_SEQ_EN
                  state_d   = S_SEQ;
                  tx_data_d = seq_q;
`else
                  state_d   = S_PAY;
                  tx_data_d = shreg_q[DATA_W-1 -: 8];
`endif
                end
`ifdef FRAME_SEQ_EN
                S_SEQ: begin
                  state_d   = S_PAY;
                  tx_data_d = shreg_q[DATA_W-1 -: 8];
                end
`endif
                S_PAY: begin
                  if (idx_q == IW'(NB - 1)) begin
                    state_d   = S_CSUM;
                    tx_data_d = csum_q;
                  end else begin
                    shreg_d   = shreg_nxt;
                    tx_data_d = shreg_nxt[DATA_W-1 -: 8];
                    idx_d     = idx_q + IW'(1);
                  end
                end
                S_CSUM: begin
                  frame_done_d = 1'b1;
                  state_d      = S_IDLE;
`ifdef FRAME_SEQ_EN
                  seq_d        = seq_q + 8'd1;
`endif
                end
                default: state_d = S_IDLE;
              endcase
            end
          end

          default: phase_d = B_ISSUE;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_uart_frame_tx_ctrl.sv
// Bench for uart_frame_tx_ctrl: UART busy model, frame-level reference model, directed + random stimulus.
// Honours FRAME_SEQ_EN the same way as the design.
module tb_uart_frame_tx_ctrl;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned NB         = DATA_W / 8;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;
`ifdef FRAME_SEQ_EN
  localparam int unsigned FL = NB + 3;
`else
  localparam int unsigned FL = NB + 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [CW-1:0]     fifo_count;
  logic              frame_done;

  uart_frame_tx_ctrl #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .fifo_count(fifo_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // UART transmitter model: busy rises the cycle after start and stays high 10 cycles
  int   busy_cnt  = 0;
  logic hold_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || hold_busy;

  // Reference model: every accepted word becomes SYNC, [SEQ], bytes MSB-first, XOR of all after SYNC
  logic [7:0] exp_bytes[$];
  int         frames_pushed = 0;
  logic [7:0] m_cs;
  logic [7:0] m_b;
`ifdef FRAME_SEQ_EN
  logic [7:0] m_seq = 8'h00;
`endif
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_bytes.delete();
      frames_pushed = 0;
`ifdef FRAME_SEQ_EN
      m_seq = 8'h00;
`endif
    end else if (in_valid && in_ready) begin
      m_cs = 8'h00;
      exp_bytes.push_back(8'hA5);
`ifdef FRAME_SEQ_EN
      exp_bytes.push_back(m_seq);
      m_cs  = m_cs ^ m_seq;
      m_seq = m_seq + 8'd1;
`endif
      for (int i = NB - 1; i >= 0; i--) begin
        m_b  = in_data[i*8 +: 8];
        m_cs = m_cs ^ m_b;
        exp_bytes.push_back(m_b);
      end
      exp_bytes.push_back(m_cs);
      frames_pushed = frames_pushed + 1;
    end
  end

  // Monitor: byte order, start protocol, data stability, frame length
  logic [7:0] got[$];
  logic [7:0] last_frame[$];
  logic [7:0] prev_frame[$];
  int         cur_idx = 0;
  int         frames_done = 0;
  bit         inflight = 1'b0;
  bit         saw_busy = 1'b0;
  bit         stable = 1'b1;
  logic [7:0] held = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      got.delete();
      cur_idx     = 0;
      frames_done = 0;
      inflight    = 1'b0;
    end else begin
      if (tx_start) begin
        chk("start_while_busy", 32'(tx_busy), 32'd0);
        if (exp_bytes.size() != 0) chk("tx_byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
        else chk("byte_expected", 32'(exp_bytes.size()), 32'd1);
        got.push_back(tx_data);
        cur_idx  = cur_idx + 1;
        inflight = 1'b1;
        saw_busy = 1'b0;
        stable   = 1'b1;
        held     = tx_data;
      end else if (inflight) begin
        if (tx_data !== held) stable = 1'b0;
        if (tx_busy) saw_busy = 1'b1;
        else if (saw_busy) begin
          chk("tx_data_stable", 32'(stable), 32'd1);
          inflight = 1'b0;
        end
      end
      if (frame_done) begin
        chk("frame_len", 32'(cur_idx), 32'(FL));
        prev_frame  = last_frame;
        last_frame  = got;
        got.delete();
        cur_idx     = 0;
        frames_done = frames_done + 1;
      end
    end
  end

  task automatic send_word(input logic [DATA_W-1:0] w, input int budget);
    bit ok = 1'b0;
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end else @(negedge clk);
    end
    #1 in_valid = 1'b0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_start(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      #1;
      if (tx_start) seen = 1'b1;
    end
    chk("wait_start", 32'(seen), 32'd1);
  endtask

  task automatic drain(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (frames_done == frames_pushed && fifo_count == '0 && exp_bytes.size() == 0 && !tx_busy)
        ok = 1'b1;
    end
    repeat (2) @(negedge clk);
    chk("drain", 32'(ok), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_start"},   32'(tx_start),   32'd0);
    chk({tag, "_tx_data"},    32'(tx_data),    32'h00);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
  endtask

  initial begin
    logic [7:0] e1[FL];
    logic [7:0] e5a[FL];
    logic [7:0] e5b[FL];
    logic [7:0] hd;
    int         lat;
    int         n_start;
    int         n_chg;
    int         f0;
    bit         seen;
`ifdef FRAME_SEQ_EN
    e1  = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h26};
    e5a = '{8'hA5, 8'h00, 8'h00, 8'hFF, 8'hFF};
    e5b = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'hFE};
`else
    e1  = '{8'hA5, 8'h12, 8'h34, 8'h26};
    e5a = '{8'hA5, 8'h00, 8'hFF, 8'hFF};
    e5b = '{8'hA5, 8'h00, 8'hFF, 8'hFF};
`endif

    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 0x1234 and push-to-start latency
    f0 = frames_done;
    in_data  = 16'h1234;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat = lat + 1;
      if (tx_start) seen = 1'b1;
    end
    chk("first_start_latency", 32'(lat), 32'd3);
    drain(1000);
    chk("t1_frame_done_pulses", 32'(frames_done - f0), 32'd1);
    chk("t1_fifo_count", 32'(fifo_count), 32'd0);
    chk("t1_len", 32'(last_frame.size()), 32'(FL));
    for (int i = 0; i < int'(FL) && i < last_frame.size(); i++)
      chk($sformatf("t1_byte%0d", i), 32'(last_frame[i]), 32'(e1[i]));

    // Back-pressure: busy held 50 cycles while a byte is pending
    send_word(16'hBEEF, 100);
    wait_start(100);
    @(posedge clk);
    #1 hold_busy = 1'b1;
    hd      = tx_data;
    n_start = 0;
    n_chg   = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (tx_start) n_start = n_start + 1;
      if (tx_data !== hd) n_chg = n_chg + 1;
    end
    chk("t4_held_byte", 32'(hd), 32'hA5);
    chk("t4_starts_during_hold", 32'(n_start), 32'd0);
    chk("t4_tx_data_changes", 32'(n_chg), 32'd0);
    hold_busy = 1'b0;
    wait_start(20);
    drain(1000);

    // Simultaneous push and pop with two words queued
    send_word(16'h1111, 100);
    send_word(16'h2222, 100);
    send_word(16'h3333, 100);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk("t3_frame_done_seen", 32'(seen), 32'd1);
    chk("t3_count_before", 32'(fifo_count), 32'd2);
    in_data  = 16'h4444;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("t3_count_after", 32'(fifo_count), 32'd2);
    drain(2000);

    // FIFO full while the framer is stalled mid-frame
    send_word(16'hA000, 100);
    wait_start(100);
    @(posedge clk);
    #1 hold_busy = 1'b1;
    for (int k = 1; k <= 4; k++) send_word(DATA_W'(16'hA000 + k), 10);
    chk("t2_count_full", 32'(fifo_count), 32'(FIFO_DEPTH));
    chk("t2_ready_full", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_data  = 16'hA005;
    in_valid = 1'b1;
    n_chg = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready || fifo_count != CW'(FIFO_DEPTH)) n_chg = n_chg + 1;
    end
    chk("t2_held_off_cycles", 32'(n_chg), 32'd0);
    @(posedge clk);
    #1 hold_busy = 1'b0;
    send_word(16'hA005, 3000);
    drain(5000);

    // Randomized traffic with random back-pressure bursts
    for (int k = 0; k < 24; k++) begin
      send_word(DATA_W'($urandom), 3000);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        if (!tx_start) hold_busy = 1'b1;
        repeat ($urandom_range(5, 40)) @(posedge clk);
        #1 hold_busy = 1'b0;
      end
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    drain(20000);

    // Asynchronous reset in the middle of the payload
    send_word(16'h5A5A, 100);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (cur_idx >= 3) seen = 1'b1;
    end
    chk("t6_reached_payload", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_word(16'hC3C3, 100);
    drain(2000);
    chk("t6_frames_after_reset", 32'(frames_done), 32'd1);
    chk("t6_new_frame_sync", 32'(last_frame[0]), 32'hA5);
    chk("t6_new_frame_len", 32'(last_frame.size()), 32'(FL));

    // Two frames of 0x00FF from a clean reset
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_word(16'h00FF, 100);
    send_word(16'h00FF, 100);
    drain(2000);
    chk("t5_len_a", 32'(prev_frame.size()), 32'(FL));
    chk("t5_len_b", 32'(last_frame.size()), 32'(FL));
    for (int i = 0; i < int'(FL) && i < prev_frame.size(); i++)
      chk($sformatf("t5a_byte%0d", i), 32'(prev_frame[i]), 32'(e5a[i]));
    for (int i = 0; i < int'(FL) && i < last_frame.size(); i++)
      chk($sformatf("t5b_byte%0d", i), 32'(last_frame[i]), 32'(e5b[i]));

    chk("final_fifo_empty", 32'(fifo_count), 32'd0);
    chk("final_exp_empty", 32'(exp_bytes.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
